// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_LO_H = 4'b0011;
    localparam logic [3:0] BE_HI_H = 4'b1100;

    // Loads size off SpLoad/BorH, stores off SpecialIn/DMemBorH; anything else is a full word.
    function automatic lsu_size_e decode_size(input logic sp_load, input logic borh,
                                              input logic special_in, input logic dmem_borh);
        if ((sp_load && !borh) || (special_in && !dmem_borh)) begin
            return SZ_B;
        end
        if ((sp_load && borh) || (special_in && dmem_borh)) begin
            return SZ_H;
        end
        return SZ_W;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatter: store byte enables / replicated write data,
// and sub-word extraction with sign or zero extension for loads.
module dmem_lane_fmt import dmem_lsu_pkg::*; (
    input  lsu_size_e   size,
    input  logic [1:0]  off,
    input  logic        zero_ext,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (off)
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            2'd3:    byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Halfwords pick their lane from off[1] only; off[0] never moves a halfword.
    always_comb begin
        be        = BE_WORD;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << off;
                wdata     = {4{store_data[7:0]}};
                load_data = zero_ext ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_H: begin
                be        = off[1] ? BE_HI_H : BE_LO_H;
                wdata     = {2{store_data[15:0]}};
                load_data = zero_ext ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                be        = BE_WORD;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Multi-cycle load/store unit with a single req/ack data-memory port.
// Optional misalignment trap enabled by defining LSU_ALIGN_CHECK_EN.
module dmem_lsu import dmem_lsu_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemtoReg,
    input  logic              MemWrite,
    input  logic              SpLoad,
    input  logic              BorH,
    input  logic              SorU,
    input  logic              SpecialIn,
    input  logic              DMemBorH,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Stall,
    output logic [DATA_W-1:0] LoadData,
    output logic              LoadValid,
    output logic              AlignErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e  state, state_d;
    lsu_size_e   size_in, size_q, fmt_size;
    logic [1:0]  off_q, fmt_off;
    logic        zext_q, fmt_zext;
    logic        is_load_q;
    logic        access, start, misalign;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata, fmt_load;

    assign access  = MemtoReg | MemWrite;
    assign size_in = decode_size(SpLoad, BorH, SpecialIn, DMemBorH);
    assign start   = (state == ST_IDLE) && access;

`ifdef LSU_ALIGN_CHECK_EN
    logic align_err_q;
    assign misalign = ((size_in == SZ_H) && Addr[0]) ||
                      ((size_in == SZ_W) && (Addr[1:0] != 2'b00));
    assign AlignErr = (state == ST_DONE) && align_err_q;
`else
    assign misalign = 1'b0;
    assign AlignErr = 1'b0;
`endif

    // The formatter sees live inputs while launching and the captured access while waiting for data.
    assign fmt_size = (state == ST_IDLE) ? size_in : size_q;
    assign fmt_off  = (state == ST_IDLE) ? Addr[1:0] : off_q;
    assign fmt_zext = (state == ST_IDLE) ? SorU : zext_q;

    dmem_lane_fmt u_lane_fmt (
        .size       (fmt_size),
        .off        (fmt_off),
        .zero_ext   (fmt_zext),
        .store_data (WData),
        .rdata      (mem_rdata),
        .be         (fmt_be),
        .wdata      (fmt_wdata),
        .load_data  (fmt_load)
    );

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (access) state_d = misalign ? ST_DONE : ST_BUSY;
            ST_BUSY: if (mem_ack) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign Stall     = start || (state == ST_BUSY);
    assign LoadValid = (state == ST_DONE) && is_load_q && !AlignErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            size_q    <= SZ_W;
            off_q     <= 2'b00;
            zext_q    <= 1'b0;
            is_load_q <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            LoadData  <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            state <= state_d;
            if (start) begin
                size_q    <= size_in;
                off_q     <= Addr[1:0];
                zext_q    <= SorU;
                is_load_q <= !MemWrite;
`ifdef LSU_ALIGN_CHECK_EN
                align_err_q <= misalign;
`endif
                if (!misalign) begin
                    mem_req   <= 1'b1;
                    mem_we    <= MemWrite;
                    mem_addr  <= {Addr[ADDR_W-1:2], 2'b00};
                    mem_be    <= MemWrite ? fmt_be : BE_WORD;
                    mem_wdata <= fmt_wdata;
                end
            end
            if ((state == ST_BUSY) && mem_ack) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (is_load_q) LoadData <= fmt_load;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed, table-driven bench for dmem_lsu plus hand-written reset and
// alignment sequences (alignment path follows LSU_ALIGN_CHECK_EN).
module tb_dmem_lsu;

    typedef struct {
        logic        memtoreg, memwrite, spload, borh, soru, specialin, dmemborh;
        logic [31:0] addr, wdata, rdata;
        int          ack_delay;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic [31:0] exp_load;
        logic        exp_valid;
        int          exp_stall;
    } lsu_vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemtoReg, MemWrite, SpLoad, BorH, SorU, SpecialIn, DMemBorH;
    logic [31:0] Addr, WData;
    logic        Stall, LoadValid, AlignErr;
    logic [31:0] LoadData;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int check_cnt = 0;
    int pass_cnt  = 0;
    lsu_vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_lsu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemtoReg  (MemtoReg),
        .MemWrite  (MemWrite),
        .SpLoad    (SpLoad),
        .BorH      (BorH),
        .SorU      (SorU),
        .SpecialIn (SpecialIn),
        .DMemBorH  (DMemBorH),
        .Addr      (Addr),
        .WData     (WData),
        .Stall     (Stall),
        .LoadData  (LoadData),
        .LoadValid (LoadValid),
        .AlignErr  (AlignErr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic lsu_vec_t mk(input logic mt, mw, sp, bh, su, si, db,
                                    input logic [31:0] a, wd, rd, input int dly,
                                    input logic [31:0] ea, input logic [3:0] ebe,
                                    input logic [31:0] ewd, input logic ewe,
                                    input logic [31:0] eld, input logic evld, input int estall);
        lsu_vec_t v;
        v.memtoreg = mt; v.memwrite = mw; v.spload = sp; v.borh = bh; v.soru = su;
        v.specialin = si; v.dmemborh = db; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.ack_delay = dly; v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd;
        v.exp_we = ewe; v.exp_load = eld; v.exp_valid = evld; v.exp_stall = estall;
        return v;
    endfunction

    task automatic clearInputs();
        MemtoReg = 0; MemWrite = 0; SpLoad = 0; BorH = 0; SorU = 0;
        SpecialIn = 0; DMemBorH = 0; Addr = '0; WData = '0;
    endtask

    // One full transaction: IDLE-detect, BUSY with ack after ack_delay wait cycles, DONE.
    task automatic applyStimulus(input lsu_vec_t v, input string tag);
        int stall_cnt = 0;
        @(negedge clk);
        MemtoReg = v.memtoreg; MemWrite = v.memwrite; SpLoad = v.spload; BorH = v.borh;
        SorU = v.soru; SpecialIn = v.specialin; DMemBorH = v.dmemborh;
        Addr = v.addr; WData = v.wdata; mem_ack = 0;
        #1;
        if (Stall) stall_cnt++;
        checkOutput({tag, " idle_stall"}, 32'(Stall), 32'h1);
        for (int w = 0; w <= v.ack_delay; w++) begin
            @(negedge clk);
            if (Stall) stall_cnt++;
            checkOutput($sformatf("%s busy%0d mem_req", tag, w), 32'(mem_req), 32'h1);
            checkOutput($sformatf("%s busy%0d mem_we", tag, w), 32'(mem_we), 32'(v.exp_we));
            checkOutput($sformatf("%s busy%0d mem_addr", tag, w), mem_addr, v.exp_addr);
            checkOutput($sformatf("%s busy%0d mem_be", tag, w), 32'(mem_be), 32'(v.exp_be));
            if (v.memwrite)
                checkOutput($sformatf("%s busy%0d mem_wdata", tag, w), mem_wdata, v.exp_wdata);
            checkOutput($sformatf("%s busy%0d LoadValid", tag, w), 32'(LoadValid), 32'h0);
            mem_ack   = (w == v.ack_delay);
            mem_rdata = mem_ack ? v.rdata : 32'h0BAD0BAD;
        end
        @(negedge clk);
        mem_ack = 0;
        mem_rdata = 32'h0BAD0BAD;
        if (Stall) stall_cnt++;
        checkOutput({tag, " done LoadValid"}, 32'(LoadValid), 32'(v.exp_valid));
        checkOutput({tag, " done LoadData"}, LoadData, v.exp_load);
        checkOutput({tag, " done AlignErr"}, 32'(AlignErr), 32'h0);
        checkOutput({tag, " done mem_req"}, 32'(mem_req), 32'h0);
        checkOutput({tag, " stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
        clearInputs();
    endtask

    initial begin
        //          mt mw sp bh su si db addr          wdata         rdata         dly  exp_addr     be       exp_wdata     we  exp_load      vld stall
        vecs.push_back(mk(0,1,0,0,0,0,0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 32'h10, 4'b1111, 32'hDEADBEEF, 1, 32'h0,        0, 2));
        vecs.push_back(mk(0,1,0,0,0,1,0, 32'h13, 32'h000000A5, 32'h0,        0, 32'h10, 4'b1000, 32'hA5A5A5A5, 1, 32'h0,        0, 2));
        vecs.push_back(mk(0,1,0,0,0,1,1, 32'h06, 32'h1234BEEF, 32'h0,        1, 32'h04, 4'b1100, 32'hBEEFBEEF, 1, 32'h0,        0, 3));
        vecs.push_back(mk(1,0,1,0,0,0,0, 32'h21, 32'h11111111, 32'h0000F000, 0, 32'h20, 4'b1111, 32'h0,        0, 32'hFFFFFFF0, 1, 2));
        vecs.push_back(mk(1,0,1,0,1,0,0, 32'h21, 32'h11111111, 32'h0000F000, 0, 32'h20, 4'b1111, 32'h0,        0, 32'h000000F0, 1, 2));
        vecs.push_back(mk(1,0,1,1,1,0,0, 32'h22, 32'h11111111, 32'h80010000, 0, 32'h20, 4'b1111, 32'h0,        0, 32'h00008001, 1, 2));
        vecs.push_back(mk(1,0,1,1,0,0,0, 32'h22, 32'h11111111, 32'h80010000, 2, 32'h20, 4'b1111, 32'h0,        0, 32'hFFFF8001, 1, 4));
        vecs.push_back(mk(1,0,0,0,0,0,0, 32'h30, 32'h11111111, 32'h12345678, 3, 32'h30, 4'b1111, 32'h0,        0, 32'h12345678, 1, 5));
        vecs.push_back(mk(1,0,1,0,0,0,0, 32'h1C, 32'h11111111, 32'h8899AA7F, 0, 32'h1C, 4'b1111, 32'h0,        0, 32'h0000007F, 1, 2));
        vecs.push_back(mk(1,0,1,0,0,0,0, 32'h1F, 32'h11111111, 32'h80FFFFFF, 0, 32'h1C, 4'b1111, 32'h0,        0, 32'hFFFFFF80, 1, 2));
        vecs.push_back(mk(0,1,0,0,0,1,0, 32'h41, 32'hFFFFFF3C, 32'h0,        0, 32'h40, 4'b0010, 32'h3C3C3C3C, 1, 32'hFFFFFF80, 0, 2));

        clearInputs();
        mem_ack = 0;
        mem_rdata = 32'h0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset Stall", 32'(Stall), 32'h0);
        checkOutput("reset LoadData", LoadData, 32'h0);
        checkOutput("reset LoadValid", 32'(LoadValid), 32'h0);
        checkOutput("reset AlignErr", 32'(AlignErr), 32'h0);
        checkOutput("reset mem_req", 32'(mem_req), 32'h0);
        checkOutput("reset mem_we", 32'(mem_we), 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_be", 32'(mem_be), 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);
        rst_n = 1;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a load: request must drop at once and a late ack must be ignored.
        @(negedge clk);
        MemtoReg = 1; Addr = 32'h50;
        @(negedge clk);
        checkOutput("rst_mid busy mem_req", 32'(mem_req), 32'h1);
        rst_n = 0;
        clearInputs();
        #1;
        checkOutput("rst_mid mem_req", 32'(mem_req), 32'h0);
        checkOutput("rst_mid Stall", 32'(Stall), 32'h0);
        checkOutput("rst_mid LoadData", LoadData, 32'h0);
        @(negedge clk);
        rst_n = 1;
        mem_ack = 1;
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 0;
        checkOutput("stray_ack LoadValid", 32'(LoadValid), 32'h0);
        checkOutput("stray_ack LoadData", LoadData, 32'h0);
        checkOutput("stray_ack mem_req", 32'(mem_req), 32'h0);
        checkOutput("stray_ack Stall", 32'(Stall), 32'h0);
        applyStimulus(mk(1,0,0,0,0,0,0, 32'h54, 32'h0, 32'hCAFEF00D, 0, 32'h54, 4'b1111, 32'h0, 0,
                         32'hCAFEF00D, 1, 2), "post_rst_lw");

`ifdef LSU_ALIGN_CHECK_EN
        @(negedge clk);
        MemtoReg = 1; SpLoad = 1; BorH = 1; Addr = 32'h05;
        #1;
        checkOutput("align idle Stall", 32'(Stall), 32'h1);
        @(negedge clk);
        checkOutput("align done AlignErr", 32'(AlignErr), 32'h1);
        checkOutput("align done LoadValid", 32'(LoadValid), 32'h0);
        checkOutput("align done mem_req", 32'(mem_req), 32'h0);
        checkOutput("align done Stall", 32'(Stall), 32'h0);
        checkOutput("align done LoadData", LoadData, 32'hCAFEF00D);
        clearInputs();
        @(negedge clk);
        checkOutput("align after AlignErr", 32'(AlignErr), 32'h0);
        checkOutput("align after mem_req", 32'(mem_req), 32'h0);
`else
        applyStimulus(mk(1,0,1,1,0,0,0, 32'h05, 32'h0, 32'hABCD8765, 0, 32'h04, 4'b1111, 32'h0, 0,
                         32'hFFFF8765, 1, 2), "lh_odd");
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Multi-cycle load/store unit sitting directly downstream of the decoder's memory control outputs (MemtoReg, MemWrite, SpLoad, BorH, SorU, SpecialIn, DMemBorH). Turns one decoded load/store into a single request/acknowledge transaction on a word-wide data memory, generates byte enables and lane-replicated write data, and extracts/extends sub-word load data. Stalls the PC until the access completes.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; only 32 supported

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- MemtoReg  in  1  load instruction (lw/lb/lbu/lh/lhu)
- MemWrite  in  1  store instruction (sw/sb/sh)
- SpLoad  in  1  sub-word load
- BorH  in  1  sub-word load is halfword (1) or byte (0)
- SorU  in  1  sub-word load zero-extends (1) or sign-extends (0)
- SpecialIn  in  1  sub-word store
- DMemBorH  in  1  sub-word store is halfword (1) or byte (0)
- Addr  in  ADDR_W  effective byte address from ALU
- WData  in  32  store data (rt)
- Stall  out  1  hold PC/instruction
- LoadData  out  32  formatted load result
- LoadValid  out  1  LoadData valid this cycle
- AlignErr  out  1  misaligned-access pulse
- mem_req  out  1  memory request
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  word address, bits [1:0] always 0
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completion, one cycle
- mem_rdata  in  32  read data, valid with mem_ack

## Operation
- Access = MemtoReg | MemWrite. Size: byte if (SpLoad & ~BorH) or (SpecialIn & ~DMemBorH); half if (SpLoad & BorH) or (SpecialIn & DMemBorH); else word.
- FSM states IDLE, BUSY, DONE. IDLE: on Access, register address, size, sign, direction, formatted write data and byte enables; go BUSY. BUSY: mem_req=1, all mem_* stable until mem_ack; on mem_ack latch formatted load into LoadData, go DONE. DONE: one cycle, LoadValid=1 for loads only; go IDLE unconditionally.
- Stall = (IDLE & Access) | BUSY. Stall=0 in DONE so the CPU advances; Access seen in DONE is not re-triggered.
- Store lanes: off=Addr[1:0]. sb: be=1<<off, wdata={4{WData[7:0]}}. sh: be=Addr[1]?1100:0011, wdata={2{WData[15:0]}}. sw: be=1111, wdata=WData. Loads: be=1111.
- Load extract: lb/lbu byte lane off; lh/lhu halfword lane Addr[1]; extend per SorU; lw unmodified.
- mem_ack outside BUSY ignored. Reset mid-transaction: FSM to IDLE, mem_req drops immediately; memory must tolerate abandoned requests.

## Timing
- Reset values: Stall=0, LoadData=0, LoadValid=0, AlignErr=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- mem_* outputs registered. Zero-wait memory (ack in first BUSY cycle): access takes 3 cycles (IDLE-detect, BUSY, DONE); each wait cycle adds one.
- LoadData holds its value until the next load completes.

## Configuration
- LSU_ALIGN_CHECK_EN defined: halfword with Addr[0]=1 or word with Addr[1:0]!=0 issues no memory request; IDLE goes straight to DONE, AlignErr=1 for that DONE cycle, LoadValid=0, LoadData unchanged, Stall=1 for one cycle.
- Undefined: no check; halfword ignores Addr[0], word ignores Addr[1:0]; AlignErr tied 0.

## Structure
- Package dmem_lsu_pkg: FSM state enum, size encoding (SZ_B, SZ_H, SZ_W), byte-enable constants BE_WORD, BE_LO_H, BE_HI_H.
- Sub-module dmem_lane_fmt (combinational): size/offset/sign in; mem_be, replicated wdata, extracted load data out. Top holds FSM and registers.

## Test plan
- sw Addr=0x10, WData=0xDEADBEEF, ack first BUSY cycle -> mem_addr=0x10, be=1111, wdata=0xDEADBEEF, we=1; Stall high 2 cycles; LoadValid never 1.
- sb Addr=0x13, WData=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, mem_addr=0x10.
- lb Addr=0x21, rdata=0x0000F000 -> LoadData=0xFFFFFFF0; lbu same -> 0x000000F0; lhu Addr=0x22, rdata=0x80010000 -> 0x00008001.
- lw with ack delayed 3 cycles -> mem_* stable throughout, Stall high 5 cycles, LoadValid one cycle after ack.
- rst_n low during BUSY -> mem_req=0 and Stall=0 immediately; later ack ignored; next lw runs normally.
- LSU_ALIGN_CHECK_EN: lh Addr=0x05 -> no mem_req, AlignErr=1 one cycle, LoadValid=0; without macro -> request at 0x04, lane 0 halfword.
